// File: rtl/carry_increment_32_bit.sv
// carry_increment_32_bit: 32-bit carry-increment adder made of four 8-bit
// blocks, with the sum and carry-out captured in one output register stage.
// {cout, sum} = a + b + cin, one clock after the operands are presented.

// One 8-bit slice: a ripple adder followed by an incrementer. Block 0 feeds the
// external carry into its ripple chain and ties inc_cin low. The upper blocks
// tie ripple_cin low and take the previous block's carry on inc_cin. This keeps
// the inter-block carry out of their ripple chains.
module carry_increment_block (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       ripple_cin,
  input  logic       inc_cin,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [7:0] p;
  logic [7:0] g;
  logic [7:0] t;
  logic [8:0] c;
  logic       blk_g;
  logic       blk_p;

  // Local ripple sum, block generate/propagate, then increment by the incoming carry.
  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c    = '0;
    t    = '0;
    c[0] = ripple_cin;
    for (int i = 0; i < 8; i++) begin
      t[i]     = p[i] ^ c[i];
      c[i + 1] = g[i] | (p[i] & c[i]);
    end
    blk_g  = c[8];
    blk_p  = &p;
    sum_o  = t + {7'b0, inc_cin};
    cout_o = blk_g | (blk_p & inc_cin);
  end

endmodule

module carry_increment_32_bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  localparam int DATA_W = 32;
  localparam int BLK_W  = 8;
  localparam int NBLK   = DATA_W / BLK_W;

  logic [DATA_W-1:0] sum_c;
  logic [NBLK-1:0]   blk_co;

  logic [DATA_W-1:0] sum_d;
  logic [DATA_W-1:0] sum_q;
  logic              cout_d;
  logic              cout_q;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    if (k == 0) begin : g_lsb
      carry_increment_block u_blk (
        .a_i        (a[k*BLK_W +: BLK_W]),
        .b_i        (b[k*BLK_W +: BLK_W]),
        .ripple_cin (cin),
        .inc_cin    (1'b0),
        .sum_o      (sum_c[k*BLK_W +: BLK_W]),
        .cout_o     (blk_co[k])
      );
    end else begin : g_upper
      carry_increment_block u_blk (
        .a_i        (a[k*BLK_W +: BLK_W]),
        .b_i        (b[k*BLK_W +: BLK_W]),
        .ripple_cin (1'b0),
        .inc_cin    (blk_co[k-1]),
        .sum_o      (sum_c[k*BLK_W +: BLK_W]),
        .cout_o     (blk_co[k])
      );
    end
  end

  // Next-state of the output register is the full combinational result.
  always_comb begin
    sum_d  = sum_c;
    cout_d = blk_co[NBLK-1];
  end

  // Output register stage; asynchronous clear discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_carry_increment_32_bit.sv
// Directed and random self-checking bench for carry_increment_32_bit.
module tb_carry_increment_32_bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;
  logic        cout;

  int checks;
  int errors;

  carry_increment_32_bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_res(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vc, input logic [32:0] exp);
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vc;
    @(posedge clk);
    #1;
    check_res(tag, {cout, sum}, exp);
  endtask

  logic [32:0] exp_prev;
  logic        have_prev;

  initial begin
    checks    = 0;
    errors    = 0;
    have_prev = 1'b0;
    exp_prev  = '0;
    rst_n     = 1'b1;
    a         = $urandom;
    b         = $urandom;
    cin       = 1'(($urandom) & 1);

    // Reset asserted before any clock edge must clear outputs at once.
    #2 rst_n = 1'b0;
    #1 check_res("rst_async", {cout, sum}, 33'h0);
    repeat (3) begin
      @(negedge clk);
      a   = $urandom;
      b   = $urandom;
      cin = 1'(($urandom) & 1);
      #1 check_res("rst_hold", {cout, sum}, 33'h0);
    end
    @(negedge clk);
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_res("rst_release_zero", {cout, sum}, 33'h0);

    run_vec("mixed",       32'h001F001F, 32'h0006000C, 1'b0, {1'b0, 32'h0025002B});
    run_vec("full_carry",  32'hFFFFFFFF, 32'h00000000, 1'b1, {1'b1, 32'h00000000});
    run_vec("full_nocarry",32'hFFFFFFFF, 32'h00000000, 1'b0, {1'b0, 32'hFFFFFFFF});
    run_vec("blk0_to_blk1",32'h000000FF, 32'h00000001, 1'b0, {1'b0, 32'h00000100});
    run_vec("blk2_to_blk3",32'h00FFFFFF, 32'h00000000, 1'b1, {1'b0, 32'h01000000});
    run_vec("max_max_cin", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, {1'b1, 32'hFFFFFFFF});
    run_vec("msb_msb",     32'h80000000, 32'h80000000, 1'b0, {1'b1, 32'h00000000});
    run_vec("blk1_to_blk2",32'h0000FF00, 32'h00000100, 1'b0, {1'b0, 32'h00010000});
    run_vec("cin_only",    32'h00000000, 32'h00000000, 1'b1, {1'b0, 32'h00000001});

    // Back-to-back random operands with occasional asynchronous reset pulses.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (have_prev) check_res("rnd", {cout, sum}, exp_prev);
      a         = $urandom;
      b         = $urandom;
      cin       = 1'(($urandom) & 1);
      exp_prev  = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      have_prev = 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #1 check_res("rnd_rst", {cout, sum}, 33'h0);
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    check_res("rnd_last", {cout, sum}, exp_prev);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
